// File: rtl/block_pe_tile_sequencer_if.sv
// Job, operand and result handshakes of the PE tile sequencer.
// master drives jobs/operands/result-ready; slave is the sequencer.
interface block_pe_tile_sequencer_if #(
   parameter int KCNT_W = 8
);
   logic              cfg_valid_i;
   logic              cfg_ready_o;
   logic [KCNT_W-1:0] cfg_k_steps_i;
   logic [1:0]        cfg_prec_mode_i;
   logic [1:0]        cfg_fp_mode_i;
   logic [1:0]        cfg_prec_mode_quan_i;
   logic [1:0]        cfg_fp_mode_quan_i;
   logic              src_valid_i;
   logic              src_ready_o;
   logic              out_valid_o;
   logic              out_ready_i;

   modport master (
      output cfg_valid_i,
      output cfg_k_steps_i,
      output cfg_prec_mode_i,
      output cfg_fp_mode_i,
      output cfg_prec_mode_quan_i,
      output cfg_fp_mode_quan_i,
      output src_valid_i,
      output out_ready_i,
      input  cfg_ready_o,
      input  src_ready_o,
      input  out_valid_o
   );

   modport slave (
      input  cfg_valid_i,
      input  cfg_k_steps_i,
      input  cfg_prec_mode_i,
      input  cfg_fp_mode_i,
      input  cfg_prec_mode_quan_i,
      input  cfg_fp_mode_quan_i,
      input  src_valid_i,
      input  out_ready_i,
      output cfg_ready_o,
      output src_ready_o,
      output out_valid_o
   );
endinterface

// File: rtl/block_pe_tile_sequencer.sv
// Sequences one Block_PE_wrapper through clear/accumulate/drain/send.
// SEQ_BACK_TO_BACK_EN lets the next job be accepted on the result handshake.
module block_pe_tile_sequencer #(
   parameter int KCNT_W = 8,
   parameter int PE_LAT = 1
) (
   input  logic                     clk_i,
   input  logic                     rstn,
   block_pe_tile_sequencer_if.slave bus,
   output logic                     pe_a_valid_o,
   output logic                     pe_b_valid_o,
   input  logic                     pe_a_ready_i,
   input  logic                     pe_b_ready_i,
   output logic [1:0]               pe_prec_mode_o,
   output logic [1:0]               pe_fp_mode_o,
   output logic [1:0]               pe_prec_mode_quan_o,
   output logic [1:0]               pe_fp_mode_quan_o,
   output logic                     pe_clear_o,
   output logic                     pe_send_output_o,
   output logic                     busy_o,
   output logic [KCNT_W-1:0]        step_cnt_o
);

   localparam int DW = $clog2(PE_LAT + 1);
   localparam logic [DW-1:0] DRN_LD = DW'(PE_LAT);
   localparam logic [DW-1:0] DRN_ONE = DW'(1);
   localparam logic [KCNT_W-1:0] ONE = KCNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_ACCUM,
      S_DRAIN,
      S_SEND
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [KCNT_W-1:0] k_eff_q;
   logic [KCNT_W-1:0] k_eff_d;
   logic [KCNT_W-1:0] step_q;
   logic [KCNT_W-1:0] step_d;
   logic [KCNT_W-1:0] step_inc;
   logic [KCNT_W-1:0] k_in;
   logic [DW-1:0]     drn_q;
   logic [DW-1:0]     drn_d;
   logic [7:0]        mode_q;
   logic [7:0]        mode_d;

   logic in_idle;
   logic in_clear;
   logic in_accum;
   logic in_drain;
   logic in_send;
   logic pe_rdy;
   logic cfg_rdy;
   logic cfg_acc;
   logic beat;
   logic out_hs;

   assign in_idle  = (state_q == S_IDLE);
   assign in_clear = (state_q == S_CLEAR);
   assign in_accum = (state_q == S_ACCUM);
   assign in_drain = (state_q == S_DRAIN);
   assign in_send  = (state_q == S_SEND);

   assign pe_rdy = pe_a_ready_i & pe_b_ready_i;
   assign out_hs = in_send & bus.out_ready_i;

`ifdef SEQ_BACK_TO_BACK_EN
   assign cfg_rdy = in_idle | out_hs;
`else
   assign cfg_rdy = in_idle;
`endif

   assign cfg_acc  = bus.cfg_valid_i & cfg_rdy;
   assign beat     = in_accum & bus.src_valid_i & pe_rdy;
   assign step_inc = step_q + ONE;

   // A zero-length job still runs one beat.
   assign k_in = (bus.cfg_k_steps_i == '0) ? ONE
                                           : bus.cfg_k_steps_i;

   always_comb begin
      state_d = state_q;
      k_eff_d = k_eff_q;
      step_d  = step_q;
      drn_d   = drn_q;
      mode_d  = mode_q;
      unique case (1'b1)
         in_idle: ;
         in_clear: state_d = S_ACCUM;
         in_accum: begin
            if (beat) begin
               step_d = step_inc;
               if (step_inc == k_eff_q) begin
                  state_d = S_DRAIN;
                  drn_d   = DRN_LD;
               end
            end
         end
         in_drain: begin
            drn_d = drn_q - DRN_ONE;
            if (drn_q == DRN_ONE) begin
               state_d = S_SEND;
            end
         end
         in_send: begin
            if (out_hs) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (cfg_acc) begin
         state_d = S_CLEAR;
         k_eff_d = k_in;
         step_d  = '0;
         drn_d   = '0;
         mode_d  = {bus.cfg_prec_mode_i,
                    bus.cfg_fp_mode_i,
                    bus.cfg_prec_mode_quan_i,
                    bus.cfg_fp_mode_quan_i};
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         k_eff_q <= '0;
         step_q  <= '0;
         drn_q   <= '0;
         mode_q  <= '0;
      end else begin
         state_q <= state_d;
         k_eff_q <= k_eff_d;
         step_q  <= step_d;
         drn_q   <= drn_d;
         mode_q  <= mode_d;
      end
   end

   assign bus.cfg_ready_o = cfg_rdy;
   assign bus.src_ready_o = in_accum & pe_rdy;
   assign bus.out_valid_o = in_send;

   assign pe_a_valid_o     = in_accum & bus.src_valid_i;
   assign pe_b_valid_o     = in_accum & bus.src_valid_i;
   assign pe_clear_o       = in_clear;
   assign pe_send_output_o = in_send;
   assign busy_o           = ~in_idle;
   assign step_cnt_o       = step_q;

   assign {pe_prec_mode_o,
           pe_fp_mode_o,
           pe_prec_mode_quan_o,
           pe_fp_mode_quan_o} = mode_q;

`ifndef SYNTHESIS
   a_out_hold: assert property (
      @(posedge clk_i) disable iff (!rstn)
      bus.out_valid_o && !bus.out_ready_i |=> bus.out_valid_o);

   a_step_bound: assert property (
      @(posedge clk_i) disable iff (!rstn)
      step_q <= k_eff_q);

   a_mode_hold: assert property (
      @(posedge clk_i) disable iff (!rstn)
      !cfg_acc |=> $stable(mode_q));

   a_clear_pulse: assert property (
      @(posedge clk_i) disable iff (!rstn)
      pe_clear_o |=> !pe_clear_o);
`endif

endmodule

// File: tb/tb_block_pe_tile_sequencer.sv
// Scoreboard bench for block_pe_tile_sequencer: jobs pushed at config,
// popped and checked at the result handshake.
module tb_block_pe_tile_sequencer;
   localparam int KW  = 8;
   localparam int LAT = 2;

   typedef struct {
      int         k;
      logic [7:0] md;
   } exp_t;

   logic          clk_i = 1'b0;
   logic          rstn = 1'b0;
   logic          pe_a_valid_o;
   logic          pe_b_valid_o;
   logic          pe_a_ready_i;
   logic          pe_b_ready_i;
   logic [1:0]    pe_prec_mode_o;
   logic [1:0]    pe_fp_mode_o;
   logic [1:0]    pe_prec_mode_quan_o;
   logic [1:0]    pe_fp_mode_quan_o;
   logic          pe_clear_o;
   logic          pe_send_output_o;
   logic          busy_o;
   logic [KW-1:0] step_cnt_o;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   exp_t sb[$];

   int   n_clear = 0;
   int   clear_cyc = 0;
   int   acc_edge = 0;
   int   beats = 0;
   int   first_beat = 0;
   int   last_beat = 0;
   int   ov_cyc = 0;
   int   hs_edge = 0;
   int   viol = 0;
   int   ov_cnt = 0;
   logic ov_prev = 1'b0;
   logic or_prev = 1'b0;

   block_pe_tile_sequencer_if #(.KCNT_W(KW)) bus ();

   block_pe_tile_sequencer #(
      .KCNT_W(KW),
      .PE_LAT(LAT)
   ) dut (
      .clk_i               (clk_i),
      .rstn                (rstn),
      .bus                 (bus.slave),
      .pe_a_valid_o        (pe_a_valid_o),
      .pe_b_valid_o        (pe_b_valid_o),
      .pe_a_ready_i        (pe_a_ready_i),
      .pe_b_ready_i        (pe_b_ready_i),
      .pe_prec_mode_o      (pe_prec_mode_o),
      .pe_fp_mode_o        (pe_fp_mode_o),
      .pe_prec_mode_quan_o (pe_prec_mode_quan_o),
      .pe_fp_mode_quan_o   (pe_fp_mode_quan_o),
      .pe_clear_o          (pe_clear_o),
      .pe_send_output_o    (pe_send_output_o),
      .busy_o              (busy_o),
      .step_cnt_o          (step_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cyc <= cyc + 1;

   // Event monitor: handshakes seen here complete on the next rising edge.
   always @(negedge clk_i) begin
      if (!rstn) begin
         beats   <= 0;
         ov_prev <= 1'b0;
         or_prev <= 1'b0;
      end else begin
         ov_prev <= bus.out_valid_o;
         or_prev <= bus.out_ready_i;
         if ((ov_prev && !or_prev && !bus.out_valid_o) ||
             (pe_a_valid_o !== pe_b_valid_o) ||
             (pe_a_valid_o && !bus.src_valid_i) ||
             (pe_send_output_o !== bus.out_valid_o) ||
             (bus.src_ready_o && !(pe_a_ready_i && pe_b_ready_i)) ||
             ((pe_a_valid_o || bus.src_ready_o) &&
              (pe_clear_o || pe_send_output_o || !busy_o)))
            viol <= viol + 1;
         if (bus.out_valid_o || pe_send_output_o)
            ov_cnt <= ov_cnt + 1;
         if (bus.cfg_valid_i && bus.cfg_ready_o) begin
            acc_edge <= cyc + 1;
            n_clear  <= 0;
            ov_cnt   <= 0;
         end
         if (pe_clear_o) begin
            n_clear   <= n_clear + 1;
            clear_cyc <= cyc;
            beats     <= 0;
         end
         if (bus.src_valid_i && bus.src_ready_o) begin
            if (beats == 0) first_beat <= cyc + 1;
            beats     <= beats + 1;
            last_beat <= cyc + 1;
         end
         if (bus.out_valid_o && !ov_prev) ov_cyc <= cyc;
         if (bus.out_valid_o && bus.out_ready_i) hs_edge <= cyc + 1;
      end
   end

   function automatic logic [7:0] pe_md();
      return {pe_prec_mode_o, pe_fp_mode_o,
              pe_prec_mode_quan_o, pe_fp_mode_quan_o};
   endfunction

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive_cfg(input int k, input logic [7:0] md);
      exp_t e;
      int   i;
      bus.cfg_k_steps_i = KW'(k);
      {bus.cfg_prec_mode_i, bus.cfg_fp_mode_i,
       bus.cfg_prec_mode_quan_i, bus.cfg_fp_mode_quan_i} = md;
      bus.cfg_valid_i = 1'b1;
      for (i = 0; i < 20; i++) begin
         #1;
         if (bus.cfg_ready_o) break;
         tick();
      end
      checks++;
      if (i == 20) begin
         errors++;
         $display("FAIL cfg_timeout got no cfg_ready_o want accept");
      end else begin
         tick();
      end
      bus.cfg_valid_i = 1'b0;
      e.k  = (k == 0) ? 1 : k;
      e.md = md;
      sb.push_back(e);
   endtask

   task automatic drive_beats(input int n, input logic [7:0] vpat,
                              input int plen, input int rlo_s,
                              input int rlo_n);
      int got = 0;
      int i = 0;
      while (got < n && i < 200) begin
         bus.src_valid_i = vpat[i % plen];
         pe_a_ready_i = !(i >= rlo_s && i < rlo_s + rlo_n);
         pe_b_ready_i = 1'b1;
         #1;
         if (bus.src_valid_i && bus.src_ready_o) got++;
         tick();
         i++;
      end
      bus.src_valid_i = 1'b0;
      pe_a_ready_i = 1'b1;
      checks++;
      if (got != n) begin
         errors++;
         $display("FAIL beat_timeout got %0d beats want %0d", got, n);
      end
   endtask

   task automatic wait_out(input int hold, input bit ign_cfg,
                           output int hi, output int crdy,
                           output logic [KW-1:0] st,
                           output logic [7:0] md);
      int i;
      hi = 0;
      crdy = 0;
      for (i = 0; i < 50; i++) begin
         #1;
         if (bus.out_valid_o) break;
         tick();
      end
      checks++;
      if (i == 50) begin
         errors++;
         $display("FAIL out_timeout got no out_valid_o want result");
      end
      if (ign_cfg) begin
         bus.cfg_k_steps_i = 8'd7;
         {bus.cfg_prec_mode_i, bus.cfg_fp_mode_i,
          bus.cfg_prec_mode_quan_i, bus.cfg_fp_mode_quan_i} = 8'hff;
      end
      for (int j = 0; j < hold; j++) begin
         bus.cfg_valid_i = ign_cfg;
         #1;
         if (bus.out_valid_o && pe_send_output_o) hi++;
         if (bus.cfg_ready_o) crdy++;
         tick();
      end
      bus.cfg_valid_i = 1'b0;
      bus.out_ready_i = 1'b1;
      #1;
      if (bus.out_valid_o && pe_send_output_o) hi++;
      st = step_cnt_o;
      md = pe_md();
      tick();
      bus.out_ready_i = 1'b0;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      bus.src_valid_i = 1'b1;
      bus.out_ready_i = 1'b1;
      repeat (3) tick();
      checks++;
      if ({pe_a_valid_o, pe_b_valid_o, bus.src_ready_o, pe_clear_o,
           pe_send_output_o, bus.out_valid_o, busy_o} !== 7'b0) begin
         errors++;
         $display("FAIL reset_ctrl got %b want 0000000",
                  {pe_a_valid_o, pe_b_valid_o, bus.src_ready_o,
                   pe_clear_o, pe_send_output_o, bus.out_valid_o, busy_o});
      end
      checks++;
      if (pe_md() !== 8'h00) begin
         errors++;
         $display("FAIL reset_modes got %h want 00", pe_md());
      end
      checks++;
      if (step_cnt_o !== '0) begin
         errors++;
         $display("FAIL reset_step got %0d want 0", step_cnt_o);
      end
      bus.src_valid_i = 1'b0;
      bus.out_ready_i = 1'b0;
      rstn = 1'b1;
      tick();
      checks++;
      if ({bus.cfg_ready_o, busy_o} !== 2'b10) begin
         errors++;
         $display("FAIL reset_idle got %b want 10",
                  {bus.cfg_ready_o, busy_o});
      end
   endtask

   task automatic test_basic();
      exp_t e;
      int hi, crdy;
      logic [KW-1:0] st;
      logic [7:0] md;
      drive_cfg(2, 8'h00);
      drive_beats(2, 8'h01, 1, 0, 0);
      wait_out(0, 1'b0, hi, crdy, st, md);
      e = sb.pop_front();
      checks++;
      if (st !== KW'(e.k)) begin
         errors++;
         $display("FAIL basic_step got %0d want %0d", st, e.k);
      end
      checks++;
      if (md !== e.md) begin
         errors++;
         $display("FAIL basic_modes got %h want %h", md, e.md);
      end
      checks++;
      if (beats != 2) begin
         errors++;
         $display("FAIL basic_beats got %0d want 2", beats);
      end
      checks++;
      if (n_clear != 1 || clear_cyc != acc_edge) begin
         errors++;
         $display("FAIL basic_clear got n=%0d at %0d want 1 at %0d",
                  n_clear, clear_cyc, acc_edge);
      end
      checks++;
      if (first_beat != acc_edge + 2) begin
         errors++;
         $display("FAIL basic_first got %0d want %0d",
                  first_beat, acc_edge + 2);
      end
      checks++;
      if (ov_cyc != last_beat + LAT) begin
         errors++;
         $display("FAIL basic_lat got %0d want %0d",
                  ov_cyc, last_beat + LAT);
      end
      checks++;
      if ({bus.cfg_ready_o, busy_o, bus.out_valid_o} !== 3'b100) begin
         errors++;
         $display("FAIL basic_idle got %b want 100",
                  {bus.cfg_ready_o, busy_o, bus.out_valid_o});
      end
   endtask

   task automatic test_gapped();
      exp_t e;
      int hi, crdy;
      logic [KW-1:0] st;
      logic [7:0] md;
      drive_cfg(2, 8'h00);
      drive_beats(2, 8'h05, 3, 1, 2);
      wait_out(0, 1'b0, hi, crdy, st, md);
      e = sb.pop_front();
      checks++;
      if (st !== KW'(e.k) || beats != 2) begin
         errors++;
         $display("FAIL gap_step got %0d/%0d want %0d",
                  st, beats, e.k);
      end
      checks++;
      if (md !== e.md) begin
         errors++;
         $display("FAIL gap_modes got %h want %h", md, e.md);
      end
      checks++;
      if (viol != 0) begin
         errors++;
         $display("FAIL gap_protocol got %0d viol want 0", viol);
      end
   endtask

   task automatic test_k_zero();
      exp_t e;
      int hi, crdy;
      logic [KW-1:0] st;
      logic [7:0] md;
      drive_cfg(0, 8'h66);
      drive_beats(1, 8'h01, 1, 0, 0);
      bus.src_valid_i = 1'b1;
      wait_out(0, 1'b0, hi, crdy, st, md);
      bus.src_valid_i = 1'b0;
      e = sb.pop_front();
      checks++;
      if (st !== KW'(e.k) || beats != 1) begin
         errors++;
         $display("FAIL k0_step got %0d/%0d want 1", st, beats);
      end
      checks++;
      if (md !== e.md) begin
         errors++;
         $display("FAIL k0_modes got %h want %h", md, e.md);
      end
      checks++;
      if (hs_edge - acc_edge != 3 + LAT) begin
         errors++;
         $display("FAIL k0_min_job got %0d want %0d",
                  hs_edge - acc_edge, 3 + LAT);
      end
      checks++;
      if (ov_cyc != last_beat + LAT) begin
         errors++;
         $display("FAIL k0_lat got %0d want %0d",
                  ov_cyc, last_beat + LAT);
      end
   endtask

   task automatic test_backpressure();
      exp_t e;
      int hi, crdy;
      logic [KW-1:0] st;
      logic [7:0] md;
      drive_cfg(3, 8'h9c);
      drive_beats(3, 8'h01, 1, 0, 0);
      wait_out(5, 1'b1, hi, crdy, st, md);
      e = sb.pop_front();
      checks++;
      if (hi != 6) begin
         errors++;
         $display("FAIL bp_hold got %0d want 6", hi);
      end
      checks++;
      if (crdy != 0) begin
         errors++;
         $display("FAIL bp_cfg_ignored got %0d want 0", crdy);
      end
      checks++;
      if (st !== KW'(e.k) || md !== e.md) begin
         errors++;
         $display("FAIL bp_result got %0d/%h want %0d/%h",
                  st, md, e.k, e.md);
      end
      checks++;
      if (busy_o !== 1'b0 || pe_md() !== e.md) begin
         errors++;
         $display("FAIL bp_idle got %b/%h want 0/%h",
                  busy_o, pe_md(), e.md);
      end
      checks++;
      if (viol != 0) begin
         errors++;
         $display("FAIL bp_protocol got %0d viol want 0", viol);
      end
   endtask

   task automatic test_abort();
      exp_t e;
      int hi, crdy;
      logic [KW-1:0] st;
      logic [7:0] md;
      drive_cfg(4, 8'h5a);
      drive_beats(1, 8'h01, 1, 0, 0);
      checks++;
      if (step_cnt_o !== KW'(1)) begin
         errors++;
         $display("FAIL abort_mid got %0d want 1", step_cnt_o);
      end
      bus.src_valid_i = 1'b1;
      rstn = 1'b0;
      tick();
      checks++;
      if ({pe_a_valid_o, bus.src_ready_o, pe_clear_o, pe_send_output_o,
           bus.out_valid_o, busy_o} !== 6'b0 ||
          step_cnt_o !== '0 || pe_md() !== 8'h00) begin
         errors++;
         $display("FAIL abort_reset got %b/%0d/%h want 0/0/00",
                  {pe_a_valid_o, bus.src_ready_o, pe_clear_o,
                   pe_send_output_o, bus.out_valid_o, busy_o},
                  step_cnt_o, pe_md());
      end
      bus.src_valid_i = 1'b0;
      rstn = 1'b1;
      void'(sb.pop_back());
      repeat (6) tick();
      checks++;
      if (ov_cnt != 0) begin
         errors++;
         $display("FAIL abort_no_out got %0d want 0", ov_cnt);
      end
      drive_cfg(1, 8'hc3);
      drive_beats(1, 8'h01, 1, 0, 0);
      wait_out(0, 1'b0, hi, crdy, st, md);
      e = sb.pop_front();
      checks++;
      if (st !== KW'(e.k) || md !== e.md) begin
         errors++;
         $display("FAIL abort_fresh got %0d/%h want %0d/%h",
                  st, md, e.k, e.md);
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      exp_t e2;
      int hi, crdy, h, i, gap;
      logic [KW-1:0] st;
      logic [7:0] md;
      bit got;
`ifdef SEQ_BACK_TO_BACK_EN
      gap = 0;
`else
      gap = 1;
`endif
      drive_cfg(2, 8'h66);
      drive_beats(2, 8'h01, 1, 0, 0);
      for (i = 0; i < 50; i++) begin
         #1;
         if (bus.out_valid_o) break;
         tick();
      end
      e = sb.pop_front();
      bus.cfg_k_steps_i = 8'd3;
      {bus.cfg_prec_mode_i, bus.cfg_fp_mode_i,
       bus.cfg_prec_mode_quan_i, bus.cfg_fp_mode_quan_i} = 8'hcc;
      bus.cfg_valid_i = 1'b1;
      bus.out_ready_i = 1'b1;
      #1;
      md = pe_md();
      st = step_cnt_o;
      h = cyc + 1;
      got = 1'b0;
      for (int j = 0; j < 5; j++) begin
         if (bus.cfg_ready_o) begin
            got = 1'b1;
            tick();
            break;
         end
         tick();
         bus.out_ready_i = 1'b0;
         #1;
      end
      bus.cfg_valid_i = 1'b0;
      bus.out_ready_i = 1'b0;
      e2.k = 3;
      e2.md = 8'hcc;
      sb.push_back(e2);
      checks++;
      if (!got || st !== KW'(e.k) || md !== e.md) begin
         errors++;
         $display("FAIL b2b_first got %0b/%0d/%h want 1/%0d/%h",
                  got, st, md, e.k, e.md);
      end
      checks++;
      if (pe_md() !== 8'hcc) begin
         errors++;
         $display("FAIL b2b_switch got %h want cc", pe_md());
      end
      drive_beats(3, 8'h01, 1, 0, 0);
      checks++;
      if (clear_cyc - h != gap || n_clear != 1) begin
         errors++;
         $display("FAIL b2b_gap got %0d/%0d want %0d/1",
                  clear_cyc - h, n_clear, gap);
      end
      wait_out(0, 1'b0, hi, crdy, st, md);
      e = sb.pop_front();
      checks++;
      if (st !== KW'(e.k) || md !== e.md || sb.size() != 0) begin
         errors++;
         $display("FAIL b2b_second got %0d/%h want %0d/%h",
                  st, md, e.k, e.md);
      end
      checks++;
      if (viol != 0) begin
         errors++;
         $display("FAIL b2b_protocol got %0d viol want 0", viol);
      end
   endtask

   initial begin
      bus.cfg_valid_i = 1'b0;
      bus.cfg_k_steps_i = '0;
      bus.cfg_prec_mode_i = 2'b00;
      bus.cfg_fp_mode_i = 2'b00;
      bus.cfg_prec_mode_quan_i = 2'b00;
      bus.cfg_fp_mode_quan_i = 2'b00;
      bus.src_valid_i = 1'b0;
      bus.out_ready_i = 1'b0;
      pe_a_ready_i = 1'b1;
      pe_b_ready_i = 1'b1;
      test_reset();
      test_basic();
      test_gapped();
      test_k_zero();
      test_backpressure();
      test_abort();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end
endmodule
